i2c_master_wr: RTL and testbench

//   I2C single-byte write engine; sits directly downstream of the APB register block.

---
 rtl/i2c_master_wr.sv | 146 ++++++++++++++
 tb/tb_i2c_master_wr.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write engine: START, 7-bit address + W, one data byte, STOP.
// Each bus phase is 4 quarters of CLK_DIV clocks; SCL/SDA drives are registered from next-state.
module i2c_master_wr #(
  parameter int dataWidth = 32,
  parameter int CLK_DIV   = 250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startbit,
  input  logic                 resetbit,
  input  logic                 it_enable,
  input  logic [dataWidth-1:0] per_addr,
  input  logic [dataWidth-1:0] per_data,
  input  logic                 sda_i,
  output logic                 scl_o,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 ack_err,
  output logic                 irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q;
  logic          scl_q, scl_d, oe_q, oe_d;
  logic          busy_q, done_q, ack_err_q, irq_q;

  logic accept, phase_end, ack_smp, finish;
  logic unused_hi;

  assign unused_hi = ^{per_addr[dataWidth-1:7], per_data[dataWidth-1:8]};

  assign accept    = (state_q == IDLE) && startbit && !resetbit;
  assign phase_end = (qtr_q == 2'd3) && (cnt_q == CNT_MAX);
  assign ack_smp   = ((state_q == AACK) || (state_q == DACK)) && (qtr_q == 2'd2) && (cnt_q == CNT_MAX);
  assign finish    = (state_q == STOP) && phase_end && !resetbit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) qtr_d = qtr_q + 2'd1;
    end
    if (accept) begin
      state_d = START;
      sh_d    = {per_addr[6:0], 1'b0};
    end else if (phase_end) begin
      case (state_q)
        START: begin
          state_d = ADDR;
          bit_d   = 3'd0;
        end
        ADDR, DATA: begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : DACK;
        end
        // An address NACK skips the data byte and closes the bus immediately
        AACK: begin
          state_d = ack_err_q ? STOP : DATA;
          sh_d    = data_q;
          bit_d   = 3'd0;
        end
        DACK:    state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
    if (resetbit) begin
      state_d = IDLE;
      cnt_d   = '0;
      qtr_d   = 2'd0;
      bit_d   = 3'd0;
    end
  end

  always_comb begin
    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (state_d)
      START: oe_d = qtr_d[1];
      ADDR, DATA: begin
        scl_d = qtr_d[1];
        oe_d  = ~sh_d[7];
      end
      AACK, DACK: scl_d = qtr_d[1];
      STOP: begin
        scl_d = (qtr_d != 2'd0);
        oe_d  = ~qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      sh_q      <= 8'd0;
      data_q    <= 8'd0;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      if (accept) data_q <= per_data[7:0];
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= finish;
      if (resetbit || accept)       ack_err_q <= 1'b0;
      else if (ack_smp && sda_i)    ack_err_q <= 1'b1;
      if (resetbit || accept)       irq_q <= 1'b0;
      else if (finish && it_enable) irq_q <= 1'b1;
    end
  end

  assign scl_o   = scl_q;
  assign sda_oe  = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Randomized bench for i2c_master_wr: a bus-level reference model predicts the SDA bits seen
// at each SCL rise, START/STOP conditions, done timing and status for every transaction.
module tb_i2c_master_wr;

  localparam int DW = 32;
  localparam int CD = 4;
  localparam int PH = 4 * CD;

  logic          clk = 1'b0;
  logic          reset, startbit, resetbit, it_enable, sda_i;
  logic [DW-1:0] per_addr, per_data;
  logic          scl_o, sda_oe, busy, done, ack_err, irq;

  int n_chk  = 0;
  int n_fail = 0;

  i2c_master_wr #(.dataWidth(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .startbit(startbit), .resetbit(resetbit),
    .it_enable(it_enable), .per_addr(per_addr), .per_data(per_data), .sda_i(sda_i),
    .scl_o(scl_o), .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction. inj_at: cycle of a stray startbit while busy (-1 none).
  // abort_at: cycle of an abort (-1 none), via the reset port when abort_rst=1.
  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit na, input bit nd,
                         input bit ien, input int inj_at, input int abort_at, input bit abort_rst);
    logic [31:0] exp_bits, got_bits;
    logic [7:0]  ab;
    int          exp_n, got_n, starts, stops, done_k, ndone, nph;
    bit          prev_scl, prev_oe, pull;

    ab = {a, 1'b0};
    exp_bits = '0;
    exp_n    = 0;
    for (int i = 7; i >= 0; i--) begin
      exp_bits = {exp_bits[30:0], ~ab[i]};
      exp_n++;
    end
    exp_bits = {exp_bits[30:0], 1'b0};
    exp_n++;
    if (!na) begin
      for (int i = 7; i >= 0; i--) begin
        exp_bits = {exp_bits[30:0], ~d[i]};
        exp_n++;
      end
      exp_bits = {exp_bits[30:0], 1'b0};
      exp_n++;
    end
    exp_bits = {exp_bits[30:0], 1'b1};
    exp_n++;
    nph = na ? 11 : 20;

    @(negedge clk);
    per_addr      = $urandom();
    per_addr[6:0] = a;
    per_data      = $urandom();
    per_data[7:0] = d;
    it_enable     = ien;
    sda_i         = 1'b1;
    startbit      = 1'b1;
    @(negedge clk);
    startbit = 1'b0;

    got_bits = '0; got_n = 0; starts = 0; stops = 0; done_k = -1; ndone = 0;
    prev_scl = 1'b1; prev_oe = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      if (k == 0) begin
        chk("busy_after_start", busy, 1);
        chk("status_cleared", {ack_err, irq}, 0);
      end
      if (scl_o && !prev_scl) begin
        got_bits = {got_bits[30:0], sda_oe};
        got_n++;
      end
      if (scl_o && (sda_oe != prev_oe)) begin
        if (sda_oe) starts++;
        else        stops++;
      end
      prev_scl = scl_o;
      prev_oe  = sda_oe;
      if (done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (abort_at >= 0 && k == abort_at + 1)
        chk("abort_outputs", {busy, scl_o, sda_oe, ack_err, irq}, 5'b01000);
      if (done_k >= 0 && k == done_k + 1) begin
        chk("done_one_cycle", {done, busy}, 0);
        break;
      end
      pull = (!na && (got_n == 8 || got_n == 9)) || (!nd && (got_n == 17 || got_n == 18));
      sda_i    = (sda_oe || pull) ? 1'b0 : 1'b1;
      startbit = (k == inj_at);
      resetbit = (k == abort_at) && !abort_rst;
      reset    = (k == abort_at) && abort_rst;
      @(negedge clk);
    end
    startbit = 1'b0; resetbit = 1'b0; reset = 1'b0; sda_i = 1'b1;

    if (abort_at >= 0) begin
      chk("abort_no_done", ndone, 0);
    end else begin
      chk("done_latency", done_k, PH * nph);
      chk("scl_rises", got_n, exp_n);
      chk("sda_bits", got_bits, exp_bits);
      chk("start_cond", starts, 1);
      chk("stop_cond", stops, 1);
      chk("ack_err", ack_err, (na || nd) ? 1 : 0);
      chk("irq", irq, ien ? 1 : 0);
      chk("done_count", ndone, 1);
    end
  endtask

  initial begin
    reset = 1'b1; startbit = 1'b0; resetbit = 1'b0; it_enable = 1'b0;
    sda_i = 1'b1; per_addr = '0; per_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {scl_o, sda_oe, busy, done, ack_err, irq}, 6'b100000);
    reset = 1'b0;

    run_txn(7'h50, 8'hA5, 0, 0, 0, -1, -1, 0);
    run_txn(7'h50, 8'hA5, 1, 0, 0, -1, -1, 0);
    run_txn(7'h50, 8'hA5, 0, 0, 1, -1, -1, 0);
    repeat (30) @(negedge clk);
    chk("irq_holds", irq, 1);
    run_txn(7'h50, 8'hA5, 0, 0, 0, 50, -1, 0);
    run_txn(7'h50, 8'hA5, 0, 0, 1, -1, 100, 0);
    run_txn(7'h2B, 8'h3C, 0, 1, 0, -1, -1, 0);
    run_txn(7'h7F, 8'h00, 0, 0, 0, -1, 150, 1);
    run_txn(7'h00, 8'hFF, 0, 0, 0, -1, -1, 0);

    @(negedge clk);
    startbit = 1'b1;
    resetbit = 1'b1;
    @(negedge clk);
    startbit = 1'b0;
    resetbit = 1'b0;
    chk("both_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("both_idle", {busy, scl_o, sda_oe}, 3'b010);

    for (int t = 0; t < 6; t++)
      run_txn(7'($urandom()), 8'($urandom()), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, 1'($urandom()), -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
